// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_responder : byte-lane data memory with 1-cycle extracted loads and   |
// | a zeroing sweep after reset. Optional: DMEM_MISALIGN_TRAP_EN.             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dmem_responder #(
  parameter int ADDR_W    = 10,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_ready,
  input  logic        wr_en,
  input  logic [3:0]  wbyte_en,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  input  logic [2:0]  rd_funct3,
  input  logic [31:0] addr,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        misalign_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        off;
  logic [31:0]       rd_word;
  logic              wr_go;
  logic [ADDR_W-1:0] wr_idx;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       ld_data;
  logic              ld_mis;
  logic              unused_addr;

  assign word_idx    = addr[ADDR_W+1:2];
  assign off         = addr[1:0];
  assign unused_addr = &{1'b0, addr[31:ADDR_W+2]};
  assign rd_word     = mem[word_idx];

  // The sweep borrows the single write port; requests are ignored meanwhile.
  assign wr_go   = !rst && ((state == ST_INIT) || wr_en);
  assign wr_idx  = (state == ST_INIT) ? init_cnt : word_idx;
  assign wr_be   = (state == ST_INIT) ? 4'hF : wbyte_en;
  assign wr_data = (state == ST_INIT) ? 32'h0 : wdata;

  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    byte_sel = rd_word[7:0];
    half_sel = rd_word[15:0];
    ld_data  = rd_word;
    case (off)
      2'd1: begin byte_sel = rd_word[15:8];  half_sel = rd_word[23:8];  end
      2'd2: begin byte_sel = rd_word[23:16]; half_sel = rd_word[31:16]; end
      // A halfword at offset 3 has no upper byte in this word; it reads as 0.
      2'd3: begin byte_sel = rd_word[31:24]; half_sel = {8'h00, rd_word[31:24]}; end
      default: ;
    endcase
    case (rd_funct3)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_data = {24'h0, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ld_data = {16'h0, half_sel};
      default: ld_data = rd_word;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign ld_mis = (((rd_funct3 == 3'b001) || (rd_funct3 == 3'b101)) && (off == 2'd3)) ||
                  ((rd_funct3 == 3'b010) && (off != 2'd0));
`else
  assign ld_mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INIT_ZERO ? ST_INIT : ST_READY;
      init_cnt     <= '0;
      busy         <= INIT_ZERO;
      req_ready    <= !INIT_ZERO;
      rdata_valid  <= 1'b0;
      rdata        <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      rdata_valid  <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + ADDR_W'(1);
          if (init_cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= ST_READY;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        ST_READY: begin
          if (rd_en) begin
            rdata_valid  <= 1'b1;
            rdata        <= ld_mis ? 32'h0 : ld_data;
            misalign_err <= ld_mis;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_responder : randomized bench for dmem_responder against a word    |
// | array reference model. Honours DMEM_MISALIGN_TRAP_EN.  Revision: 1.0      |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int AW = 4;
  localparam int NW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_ready;
  logic        wr_en;
  logic [3:0]  wbyte_en;
  logic [31:0] wdata;
  logic        rd_en;
  logic [2:0]  rd_funct3;
  logic [31:0] addr;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        busy;
  logic        misalign_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [NW];
  logic [31:0] exp_rdata;

  dmem_responder #(.ADDR_W(AW), .INIT_ZERO(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_ready    (req_ready),
    .wr_en        (wr_en),
    .wbyte_en     (wbyte_en),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .rd_funct3    (rd_funct3),
    .addr         (addr),
    .rdata_valid  (rdata_valid),
    .rdata        (rdata),
    .busy         (busy),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns {misaligned, load value} from the word, funct3 and byte offset.
  function automatic logic [32:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] o);
    logic [31:0] sh;
    logic [31:0] v;
    logic        mis;
    sh  = w >> (8 * o);
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = ((f3 == 3'd1 || f3 == 3'd5) && o == 2'd3) || (f3 == 3'd2 && o != 2'd0);
`endif
    case (f3)
      3'd0:    v = (sh & 32'hFF)   | (sh[7]  ? 32'hFFFFFF00 : 32'h0);
      3'd4:    v =  sh & 32'hFF;
      3'd1:    v = (sh & 32'hFFFF) | (sh[15] ? 32'hFFFF0000 : 32'h0);
      3'd5:    v =  sh & 32'hFFFF;
      default: v = w;
    endcase
    if (mis) v = 32'h0;
    return {mis, v};
  endfunction

  task automatic cycle_op(input logic we, input logic [3:0] be, input logic [31:0] wd,
                          input logic re, input logic [2:0] f3, input logic [31:0] a,
                          input string tag);
    logic [32:0] r;
    int          idx;
    idx = int'((a >> 2) % NW);
    r   = ref_load(model[idx], f3, a[1:0]);
    wr_en = we; wbyte_en = be; wdata = wd; rd_en = re; rd_funct3 = f3; addr = a;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    if (we) begin
      for (int i = 0; i < 4; i++) if (be[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
    end
    if (re) exp_rdata = r[31:0];
    check_val({tag, "_valid"}, {31'b0, rdata_valid}, {31'b0, re});
    check_val({tag, "_rdata"}, rdata, exp_rdata);
    check_val({tag, "_mis"}, {31'b0, misalign_err}, {31'b0, re & r[32]});
  endtask

  // Counts sweep cycles while hammering requests that must be ignored.
  task automatic sweep_check(input string tag);
    int n;
    int stray;
    n = 0; stray = 0;
    while (busy && n < 100) begin
      wr_en = 1'b1; wbyte_en = 4'hF; wdata = $urandom; rd_en = 1'b1;
      rd_funct3 = 3'd2; addr = $urandom;
      step();
      n++;
      if (rdata_valid || (busy && req_ready)) stray++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    check_val({tag, "_len"}, n, NW);
    check_val({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    check_val({tag, "_stray"}, stray, 0);
    for (int i = 0; i < NW; i++) model[i] = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wbyte_en = 4'h0; wdata = 32'h0;
    rd_en = 1'b0; rd_funct3 = 3'd0; addr = 32'h0; exp_rdata = 32'h0;
    step(); step();
    check_val("rst_busy",  {31'b0, busy},         32'd1);
    check_val("rst_ready", {31'b0, req_ready},    32'd0);
    check_val("rst_valid", {31'b0, rdata_valid},  32'd0);
    check_val("rst_rdata", rdata,                 32'h0);
    check_val("rst_mis",   {31'b0, misalign_err}, 32'd0);
    rst = 1'b0;
    sweep_check("sweep1");

    cycle_op(0, 4'h0, 32'h0, 1, 3'd2, 32'h3C, "t1_lw");
    check_val("t1_lit", rdata, 32'h0);

    cycle_op(1, 4'b0100, 32'h00AB0000, 0, 3'd0, 32'h8, "t2_st");
    cycle_op(0, 4'h0, 32'h0, 1, 3'd0, 32'hA, "t2_lb");
    check_val("t2_lb_lit", rdata, 32'hFFFFFFAB);
    cycle_op(0, 4'h0, 32'h0, 1, 3'd4, 32'hA, "t2_lbu");
    check_val("t2_lbu_lit", rdata, 32'h000000AB);
    cycle_op(0, 4'h0, 32'h0, 1, 3'd2, 32'h8, "t2_lw");
    check_val("t2_lw_lit", rdata, 32'h00AB0000);
    cycle_op(0, 4'h0, 32'h0, 0, 3'd0, 32'h0, "t2_hold");

    cycle_op(1, 4'b0110, 32'h0080FF00, 0, 3'd0, 32'h11, "t3_st");
    cycle_op(0, 4'h0, 32'h0, 1, 3'd1, 32'h11, "t3_lh");
    check_val("t3_lh_lit", rdata, 32'hFFFF80FF);
    cycle_op(0, 4'h0, 32'h0, 1, 3'd5, 32'h11, "t3_lhu");
    check_val("t3_lhu_lit", rdata, 32'h000080FF);

    cycle_op(1, 4'hF, 32'h11223344, 0, 3'd0, 32'h4, "t4_st");
    cycle_op(1, 4'hF, 32'hDEADBEEF, 1, 3'd2, 32'h4, "t4_rw");
    check_val("t4_rw_lit", rdata, 32'h11223344);
    cycle_op(0, 4'h0, 32'h0, 1, 3'd2, 32'h4, "t4_lw");
    check_val("t4_lw_lit", rdata, 32'hDEADBEEF);
    cycle_op(1, 4'h0, 32'h0, 1, 3'd2, 32'h4, "t4_nobe");

    cycle_op(1, 4'b1000, 32'h7F000000, 0, 3'd0, 32'h0, "t6_st");
    cycle_op(0, 4'h0, 32'h0, 1, 3'd1, 32'h3, "t6_lh");
`ifdef DMEM_MISALIGN_TRAP_EN
    check_val("t6_lit", rdata, 32'h0);
`else
    check_val("t6_lit", rdata, 32'h0000007F);
`endif
    cycle_op(0, 4'h0, 32'h0, 0, 3'd0, 32'h0, "t6_after");

    for (int k = 0; k < 300; k++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      cycle_op(op[0], 4'($urandom), $urandom, op[1], 3'($urandom), $urandom, "rand");
    end

    rst = 1'b1; rd_en = 1'b1; rd_funct3 = 3'd2; addr = 32'h4;
    step();
    rd_en = 1'b0;
    check_val("t5_valid", {31'b0, rdata_valid}, 32'd0);
    check_val("t5_busy",  {31'b0, busy},        32'd1);
    check_val("t5_ready", {31'b0, req_ready},   32'd0);
    rst = 1'b0;
    exp_rdata = 32'h0;
    sweep_check("sweep2");
    cycle_op(0, 4'h0, 32'h0, 1, 3'd2, 32'h4, "t5_lw");
    check_val("t5_lit", rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder. It receives the lane-positioned store data and byte enables that the pipeline control block produces, and it serves load requests. Loads are returned one cycle after the request, already byte-extracted and sign- or zero-extended per funct3. On reset it clears the whole array with a zeroing sweep, then accepts traffic.

Parameters:
ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words of 32 bits
INIT_ZERO, 1, 1 = run the zeroing sweep after reset; 0 = skip straight to READY

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req_ready  output  1  high when requests are accepted (READY state)
wr_en  input  1  store request this cycle
wbyte_en  input  4  byte-lane write enables; bit i writes wdata[8i+7:8i]
wdata  input  32  store data, already shifted into lane position
rd_en  input  1  load request this cycle
rd_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
addr  input  32  byte address; word index = addr[ADDR_W+1:2], offset = addr[1:0]
rdata_valid  output  1  one-cycle pulse, load result on rdata
rdata  output  32  extracted and extended load data
busy  output  1  high during the init sweep
misalign_err  output  1  misaligned-load flag (only with the optional feature)

Behaviour:
- Reset values: state=INIT (or READY if INIT_ZERO=0), init_cnt=0, busy=1 (0 if INIT_ZERO=0), req_ready=0 (1 if INIT_ZERO=0), rdata_valid=0, rdata=0, misalign_err=0.
- FSM INIT:
  - Each cycle writes 0 to mem[init_cnt] and increments init_cnt.
  - On the cycle init_cnt==DEPTH-1: the final write occurs and next state is READY.
  - The sweep lasts exactly DEPTH cycles after rst deasserts; busy=1 and req_ready=0 throughout.
  - wr_en and rd_en are ignored in INIT: no write, no rdata_valid.
- FSM READY: req_ready=1, busy=0. READY is left only via rst.
- Write:
  - When wr_en=1, lane i of the addressed word is updated iff wbyte_en[i]=1.
  - wbyte_en=0000 is a no-op.
  - Address bits above ADDR_W+1 are ignored (aliasing/wrap).
- Read:
  - rd_en=1 registers word index, offset and funct3; rdata_valid=1 with the result on the next cycle.
  - Latency is fixed at 1; back-to-back reads give back-to-back valid pulses.
  - rdata holds its value when rdata_valid=0.
- Extraction, where W is the stored word and o is the offset:
  - LB: sign-extend byte o.
  - LBU: zero-extend byte o.
  - LH: sign-extend bytes o+1:o, valid for o in {0,1,2}.
  - LHU: as LH, zero-extended.
  - LW: W, offset ignored.
  - funct3 011/110/111: rdata = W raw.
- Simultaneous rd_en and wr_en to the same word: the read returns the pre-write contents; a read on the following cycle sees the new data.
- Misaligned LH/LHU with o=3 (feature off): result is bytes {0x00, byte3} extended per funct3, i.e. the missing upper byte reads as 0.
- rst asserted mid-operation:
  - Pending read is discarded and rdata_valid=0 next cycle.
  - The sweep restarts from init_cnt=0; memory contents are lost if INIT_ZERO=1.

Optional Feature:
Macro DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A load is misaligned for LH/LHU with o=3, or LW with o≠0.
  - On the result cycle, rdata_valid=1, rdata=0 and misalign_err=1 for that single cycle.
  - Stores are not checked.
- Undefined: misalign_err is tied to 0; the extraction rules above apply unchanged.

Test Plan:
1. ADDR_W=4, INIT_ZERO=1: pulse rst, count cycles -> busy=1 for exactly 16 cycles, req_ready rises cycle 17; LW addr 0x3C -> rdata=0x00000000.
2. Store wbyte_en=0100, wdata=0x00AB0000, addr=0x8 -> next cycle LB addr 0xA gives 0xFFFFFFAB; LBU addr 0xA gives 0x000000AB; LW addr 0x8 gives 0x00AB0000.
3. Store wbyte_en=0110, wdata=0x0080FF00, addr=0x11 -> LH addr 0x11 gives 0xFFFF80FF; LHU addr 0x11 gives 0x000080FF.
4. Word 0x4 holds 0x11223344; same cycle wr_en (wbyte_en=1111, wdata=0xDEADBEEF) and rd_en LW at 0x4 -> rdata=0x11223344; next-cycle LW -> 0xDEADBEEF.
5. rd_en LW issued, rst asserted the same cycle -> rdata_valid stays 0, busy=1, full sweep repeats, previously written word reads 0.
6. Store wbyte_en=1000, wdata=0x7F000000, addr=0x0, then LH at addr 0x3 -> with DMEM_MISALIGN_TRAP_EN: rdata=0, misalign_err=1 for one cycle; without: rdata=0x0000007F, misalign_err=0.
